// File: rtl/scarf_pkg.sv
// Shared types and constants for the SCARF SPI front end and its slaves.
// Holds the frame FSM states and the header byte layout.
package scarf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } scarf_state_e;

    localparam logic [6:0] SCARF_NO_SLAVE = 7'h00;
    localparam int         RNW_BIT        = 7;
    localparam int         BYTE_BITS      = 8;

endpackage

// File: rtl/scarf_sync_edge.sv
// N-stage synchronizer for one asynchronous input, with rise/fall strobes
// derived from the synchronized value and its previous sample.
module scarf_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n_sync,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // NOTE: flops take non-blocking assignments so every stage samples the
    // value its neighbour held before this edge; blocking would collapse the chain.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/scarf_spi_frontend.sv
// SPI mode-0 slave front end for the SCARF bus: oversamples sclk/mosi/cs_n in
// the clk domain, decodes {rnw, slave_id} plus data bytes, and drives miso.
module scarf_spi_frontend
    import scarf_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n_sync,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] read_data_in,
    output logic [7:0] data_in,
    output logic       data_in_valid,
    output logic       data_in_finished,
    output logic [6:0] slave_id,
    output logic       rnw
);

    // Cycles until every synchronizer flop and edge-history flop holds a real sample.
    localparam int WARM_CYCLES = SYNC_STAGES + 1;
    localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    scarf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .din        (sclk),
        .sync       (sclk_s),
        .rise       (sclk_rise),
        .fall       (sclk_fall)
    );

    scarf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .din        (cs_n),
        .sync       (cs_s),
        .rise       (cs_rise),
        .fall       (cs_fall)
    );

    scarf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .din        (mosi),
        .sync       (mosi_s),
        .rise       (mosi_rise_unused),
        .fall       (mosi_fall_unused)
    );

    scarf_state_e      state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        data_in_q, data_in_d;
    logic              valid_q, valid_d;
    logic              finished_q, finished_d;
    logic [6:0]        slave_id_q, slave_id_d;
    logic              rnw_q, rnw_d;
    logic              end_pend_q, end_pend_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;

    logic       warm;
    logic       rise_take;
    logic       byte_done;
    logic [7:0] byte_rx;

    assign warm      = (warm_cnt_q == WARM_W'(WARM_CYCLES));
    assign rise_take = sclk_rise && (state_q != IDLE);
    assign byte_done = rise_take && (bit_cnt_q == 3'd7);
    assign byte_rx   = {rx_q[6:0], mosi_s};

    // NOTE: every _d gets a default before any branch, so no path leaves a
    // combinational output unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        data_in_d  = data_in_q;
        valid_d    = 1'b0;
        finished_d = 1'b0;
        slave_id_d = slave_id_q;
        rnw_d      = rnw_q;
        end_pend_d = 1'b0;
        warm_cnt_d = warm ? warm_cnt_q : warm_cnt_q + WARM_W'(1);

        unique case (state_q)
            IDLE: begin
                // A low cs_n seen before the chain has settled is stale and must not start a frame.
                if (cs_fall && warm) begin
                    state_d   = HEADER;
                    bit_cnt_d = 3'd0;
                    rx_d      = 8'h00;
                    tx_d      = 8'h00;
                end
            end

            default: begin
                if (rise_take) begin
                    rx_d      = byte_rx;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end

                if (byte_done) begin
                    if (state_q == HEADER) begin
                        slave_id_d = byte_rx[6:0];
                        rnw_d      = byte_rx[RNW_BIT];
                        state_d    = DATA;
                    end else begin
                        data_in_d = byte_rx;
                        valid_d   = 1'b1;
                    end
                end

                // Loads only at data-phase byte boundaries; the header shifts zeros out.
                if (sclk_fall) begin
                    if (bit_cnt_q == 3'd0 && state_q == DATA) begin
                        tx_d = read_data_in;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end

                if ((cs_rise && !byte_done) || end_pend_q) begin
                    finished_d = 1'b1;
                    slave_id_d = SCARF_NO_SLAVE;
                    rnw_d      = 1'b0;
                    tx_d       = 8'h00;
                    rx_d       = 8'h00;
                    bit_cnt_d  = 3'd0;
                    state_d    = IDLE;
                end else if (cs_rise) begin
                    // Let the completing byte publish first; close the frame next cycle.
                    end_pend_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            data_in_q  <= 8'h00;
            valid_q    <= 1'b0;
            finished_q <= 1'b0;
            slave_id_q <= SCARF_NO_SLAVE;
            rnw_q      <= 1'b0;
            end_pend_q <= 1'b0;
            warm_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            data_in_q  <= data_in_d;
            valid_q    <= valid_d;
            finished_q <= finished_d;
            slave_id_q <= slave_id_d;
            rnw_q      <= rnw_d;
            end_pend_q <= end_pend_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    assign miso             = tx_q[7];
    assign data_in          = data_in_q;
    assign data_in_valid    = valid_q;
    assign data_in_finished = finished_q;
    assign slave_id         = slave_id_q;
    assign rnw              = rnw_q;

endmodule

// File: tb/tb_scarf_spi_frontend.sv
// Self-checking bench for scarf_spi_frontend: directed SPI frames plus random
// frames compared against a byte-level model of the header/data/miso rules.
module tb_scarf_spi_frontend;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n_sync;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] read_data_in;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_finished;
    logic [6:0] slave_id;
    logic       rnw;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    scarf_spi_frontend #(.SYNC_STAGES(2)) dut (
        .clk              (clk),
        .rst_n_sync       (rst_n_sync),
        .sclk             (sclk),
        .cs_n             (cs_n),
        .mosi             (mosi),
        .miso             (miso),
        .read_data_in     (read_data_in),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .data_in_finished (data_in_finished),
        .slave_id         (slave_id),
        .rnw              (rnw)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled just after each active edge.
    logic [7:0] vq[$];
    int         vcyc[$];
    int         fin_cnt = 0;
    int         fin_cyc = -1;

    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (data_in_valid === 1'b1) begin
            vq.push_back(data_in);
            vcyc.push_back(cyc);
        end
        if (data_in_finished === 1'b1) begin
            fin_cnt = fin_cnt + 1;
            fin_cyc = cyc;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transfer stimulus and observations shared by frame tasks.
    logic [7:0] tx_bytes[$];
    logic [7:0] resp_bytes[$];
    logic [7:0] miso_got[$];
    logic [6:0] sid_got[$];
    logic       rnw_got[$];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        vq.delete();
        vcyc.delete();
        fin_cnt = 0;
        fin_cyc = -1;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_clk(HALF);
            m[7-i] = miso;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    // One complete frame; response k is held on read_data_in through byte k.
    task automatic do_xfer();
        logic [7:0] m;
        miso_got.delete();
        sid_got.delete();
        rnw_got.delete();
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < tx_bytes.size(); k++) begin
            read_data_in = (k < resp_bytes.size()) ? resp_bytes[k] : 8'h00;
            spi_bits(tx_bytes[k], 8, m);
            miso_got.push_back(m);
            wait_clk(4);
            sid_got.push_back(slave_id);
            rnw_got.push_back(rnw);
        end
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic test_reset();
        rst_n_sync   = 1'b0;
        sclk         = 1'b0;
        cs_n         = 1'b1;
        mosi         = 1'b0;
        read_data_in = 8'h00;
        wait_clk(3);
        checks++;
        if ({miso, data_in, data_in_valid, data_in_finished, slave_id, rnw} !== 19'h0) begin
            errors++;
            $display("FAIL reset_in: outputs=%0h required 0",
                     {miso, data_in, data_in_valid, data_in_finished, slave_id, rnw});
        end
        rst_n_sync = 1'b1;
        wait_clk(10);
        checks++;
        if ({miso, data_in, data_in_valid, data_in_finished, slave_id, rnw} !== 19'h0) begin
            errors++;
            $display("FAIL reset_out: outputs=%0h required 0",
                     {miso, data_in, data_in_valid, data_in_finished, slave_id, rnw});
        end
    endtask

    task automatic test_noise();
        int bad_miso;
        bad_miso = 0;
        clear_mon();
        cs_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            wait_clk(1 + $urandom_range(0, 5));
            if (miso !== 1'b0) bad_miso++;
        end
        sclk = 1'b0;
        wait_clk(HALF);
        checks++;
        if (bad_miso != 0) begin
            errors++;
            $display("FAIL noise_miso: miso high in %0d samples required 0", bad_miso);
        end
        checks++;
        if (vq.size() != 0 || fin_cnt != 0) begin
            errors++;
            $display("FAIL noise_pulses: valid=%0d finished=%0d required 0 0", vq.size(), fin_cnt);
        end
        checks++;
        if (slave_id !== 7'h00 || rnw !== 1'b0) begin
            errors++;
            $display("FAIL noise_hdr: slave_id=%0h rnw=%0b required 0 0", slave_id, rnw);
        end
    endtask

    task automatic test_write();
        logic [7:0] exp_v[$];
        exp_v = '{8'h00, 8'h10, 8'hA5};
        clear_mon();
        tx_bytes   = '{8'h02, 8'h00, 8'h10, 8'hA5};
        resp_bytes = '{};
        do_xfer();
        checks++;
        if (sid_got[0] !== 7'h02 || rnw_got[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_hdr: slave_id=%0h rnw=%0b required 02 0", sid_got[0], rnw_got[0]);
        end
        checks++;
        if (vq.size() != 3) begin
            errors++;
            $display("FAIL write_count: valid pulses=%0d required 3", vq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (vq[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL write_data%0d: got %0h required %0h", i, vq[i], exp_v[i]);
                end
            end
        end
        checks++;
        if (fin_cnt != 1) begin
            errors++;
            $display("FAIL write_finished: pulses=%0d required 1", fin_cnt);
        end
        checks++;
        if (slave_id !== 7'h00 || rnw !== 1'b0) begin
            errors++;
            $display("FAIL write_end_hdr: slave_id=%0h rnw=%0b required 0 0", slave_id, rnw);
        end
    endtask

    task automatic test_read();
        logic [7:0] exp_m[$];
        exp_m = '{8'h00, 8'h02, 8'h5A, 8'hC3};
        clear_mon();
        tx_bytes   = '{8'h82, 8'($urandom), 8'($urandom), 8'($urandom)};
        resp_bytes = '{8'h02, 8'h5A, 8'hC3, 8'h00};
        do_xfer();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (miso_got[k] !== exp_m[k]) begin
                errors++;
                $display("FAIL read_miso%0d: got %0h required %0h", k, miso_got[k], exp_m[k]);
            end
            checks++;
            if (rnw_got[k] !== 1'b1 || sid_got[k] !== 7'h02) begin
                errors++;
                $display("FAIL read_hdr%0d: slave_id=%0h rnw=%0b required 02 1", k, sid_got[k], rnw_got[k]);
            end
        end
        checks++;
        if (fin_cnt != 1 || miso !== 1'b0) begin
            errors++;
            $display("FAIL read_end: finished=%0d miso=%0b required 1 0", fin_cnt, miso);
        end
    endtask

    // Random frames against the byte-level model: header sets slave_id/rnw,
    // every later byte is a data_in pulse, miso byte k+1 carries response k.
    task automatic test_random();
        int n;
        logic [7:0] exp_m;
        for (int t = 0; t < 6; t++) begin
            clear_mon();
            n = $urandom_range(1, 5);
            tx_bytes.delete();
            resp_bytes.delete();
            for (int k = 0; k < n; k++) begin
                tx_bytes.push_back(8'($urandom));
                resp_bytes.push_back(8'($urandom));
            end
            do_xfer();
            checks++;
            if (sid_got[0] !== tx_bytes[0][6:0] || rnw_got[0] !== tx_bytes[0][7]) begin
                errors++;
                $display("FAIL rand%0d_hdr: slave_id=%0h rnw=%0b required %0h %0b",
                         t, sid_got[0], rnw_got[0], tx_bytes[0][6:0], tx_bytes[0][7]);
            end
            checks++;
            if (vq.size() != n - 1) begin
                errors++;
                $display("FAIL rand%0d_count: valid pulses=%0d required %0d", t, vq.size(), n - 1);
            end else begin
                for (int k = 1; k < n; k++) begin
                    checks++;
                    if (vq[k-1] !== tx_bytes[k]) begin
                        errors++;
                        $display("FAIL rand%0d_data%0d: got %0h required %0h", t, k, vq[k-1], tx_bytes[k]);
                    end
                end
            end
            for (int k = 0; k < n; k++) begin
                exp_m = (k == 0) ? 8'h00 : resp_bytes[k-1];
                checks++;
                if (miso_got[k] !== exp_m) begin
                    errors++;
                    $display("FAIL rand%0d_miso%0d: got %0h required %0h", t, k, miso_got[k], exp_m);
                end
            end
            checks++;
            if (fin_cnt != 1 || slave_id !== 7'h00) begin
                errors++;
                $display("FAIL rand%0d_end: finished=%0d slave_id=%0h required 1 0", t, fin_cnt, slave_id);
            end
        end
    endtask

    task automatic test_partial();
        logic [7:0] m;
        clear_mon();
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(8'h05, 8, m);
        spi_bits(8'h33, 8, m);
        spi_bits(8'hFF, 5, m);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        checks++;
        if (vq.size() != 1 || (vq.size() == 1 && vq[0] !== 8'h33)) begin
            errors++;
            $display("FAIL partial_valid: pulses=%0d first=%0h required 1 33",
                     vq.size(), (vq.size() > 0) ? vq[0] : 8'h00);
        end
        checks++;
        if (fin_cnt != 1) begin
            errors++;
            $display("FAIL partial_finished: pulses=%0d required 1", fin_cnt);
        end
        checks++;
        if (data_in !== 8'h33) begin
            errors++;
            $display("FAIL partial_hold: data_in=%0h required 33", data_in);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        clear_mon();
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(8'h02, 8, m);
        spi_bits(8'h11, 4, m);
        rst_n_sync = 1'b0;
        wait_clk(2);
        checks++;
        if ({miso, data_in, data_in_valid, data_in_finished, slave_id, rnw} !== 19'h0) begin
            errors++;
            $display("FAIL rstmid_in: outputs=%0h required 0",
                     {miso, data_in, data_in_valid, data_in_finished, slave_id, rnw});
        end
        rst_n_sync = 1'b1;
        wait_clk(2);
        clear_mon();
        spi_bits(8'h82, 8, m);
        spi_bits(8'h44, 8, m);
        wait_clk(HALF);
        checks++;
        if (vq.size() != 0 || slave_id !== 7'h00 || rnw !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ignored: valid=%0d slave_id=%0h rnw=%0b miso=%0b required 0 0 0 0",
                     vq.size(), slave_id, rnw, miso);
        end
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        checks++;
        if (fin_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_no_finish: pulses=%0d required 0", fin_cnt);
        end
        clear_mon();
        tx_bytes   = '{8'h02, 8'h11};
        resp_bytes = '{};
        do_xfer();
        checks++;
        if (sid_got[0] !== 7'h02 || vq.size() != 1 || (vq.size() == 1 && vq[0] !== 8'h11) || fin_cnt != 1) begin
            errors++;
            $display("FAIL rstmid_next: slave_id=%0h valid=%0d finished=%0d required 02 1(11) 1",
                     sid_got[0], vq.size(), fin_cnt);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] m;
        for (int d = 0; d < 2; d++) begin
            clear_mon();
            cs_n = 1'b0;
            wait_clk(HALF);
            spi_bits(8'h03, 8, m);
            spi_bits(8'h7E, 7, m);
            mosi = 1'b0;
            wait_clk(HALF);
            sclk = 1'b1;
            if (d != 0) wait_clk(d);
            cs_n = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(2 * HALF);
            checks++;
            if (vq.size() != 1 || (vq.size() == 1 && vq[0] !== 8'h7E)) begin
                errors++;
                $display("FAIL simul%0d_valid: pulses=%0d required 1 with 7e", d, vq.size());
            end
            checks++;
            if (fin_cnt != 1 || vcyc.size() != 1 || (vcyc.size() == 1 && fin_cyc != vcyc[0] + 1)) begin
                errors++;
                $display("FAIL simul%0d_order: finished=%0d fin_cyc=%0d valid_cyc=%0d required 1 valid_cyc+1",
                         d, fin_cnt, fin_cyc, (vcyc.size() > 0) ? vcyc[0] : -1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_noise();
        test_write();
        test_read();
        test_partial();
        test_reset_mid();
        test_simultaneous();
        test_random();
        test_noise();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scarf_spi_frontend.md
Name: scarf_spi_frontend

Overview:
- SPI mode-0 slave front end for the SCARF bus, running entirely in the clk domain by oversampling sclk, mosi and cs_n.
- Deserializes a one-byte header {rnw, slave_id[6:0]} followed by data bytes, and presents them to all SCARF slaves (BRAM, pattern generator, edge counters) as data_in / data_in_valid / data_in_finished / slave_id / rnw.
- Serializes the OR-combined slave read_data_out onto miso.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on sclk, mosi and cs_n (legal values ≥2).

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency.
- rst_n_sync  input  1  reset, asynchronous, active-low.
- sclk  input  1  SPI clock, asynchronous to clk; idles low.
- cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
- mosi  input  1  SPI data in, MSB first.
- miso  output  1  SPI data out, MSB first.
- read_data_in  input  8  OR of all slaves' read_data_out.
- data_in  output  8  last complete data byte received.
- data_in_valid  output  1  one-clk pulse per completed data byte (header excluded).
- data_in_finished  output  1  one-clk pulse when the transaction ends.
- slave_id  output  7  header slave id; 7'h00 means no slave is selected.
- rnw  output  1  header read-not-write bit (1 = read).

Behaviour:
- Reset: miso=0, data_in=0, data_in_valid=0, data_in_finished=0, slave_id=0, rnw=0. Internal state: FSM=IDLE, bit_cnt=0, shift registers=0, synchronizers=0, except the cs_n synchronizer, which resets to 1.
- Synchronization and edge detection: sclk, mosi and cs_n each pass through SYNC_STAGES flops. Rise/fall detection compares the last two synchronized samples of sclk and of cs_n.
- IDLE: miso=0; sclk edges are ignored. A cs_n fall moves to HEADER, clears bit_cnt and clears both shift registers.
- Bit sampling: on each sclk rise while not IDLE, shift in the synchronized mosi and increment the 3-bit bit_cnt. bit_cnt wraps 7→0, which marks a complete byte.
- HEADER byte complete: on the cycle after the 8th rise, slave_id<=rx[6:0] and rnw<=rx[7]. No data_in_valid is produced. Move to DATA.
- DATA byte complete: data_in<=rx and data_in_valid=1 for exactly one clk, registered (one cycle after the detected rise). The number of data bytes is unbounded.
- miso shift register:
  - On each sclk fall while not IDLE: if bit_cnt==0, the byte just ended, so load read_data_in; otherwise shift left.
  - Exception: the fall following the header's first bit does not load. All header-byte bits are 0.
  - miso = shift register MSB.
  - Result: read bytes appear on miso starting with data byte 1 and carry whatever read_data_in holds at that fall. With a BRAM slave this is SLAVE_ID echo, then memory data.
- Transaction end: a cs_n rise in any non-IDLE state pulses data_in_finished for one clk. On the same edge: slave_id<=0, rnw<=0, miso<=0, FSM=IDLE. Partial bits are discarded, with no data_in_valid.
- Simultaneous events: if a byte completes and cs_n rises in the same clk, data_in_valid still fires that cycle and data_in_finished fires the next cycle. The stored byte is not dropped.
- Reset mid-transaction: all state returns to reset values. The block waits in IDLE for a fresh cs_n fall; cs_n already low at reset release is ignored until it rises and falls again.
- cs_n fall while already active: no effect; only a rise ends the transaction.
- data_in holds its value between pulses and is not cleared by data_in_finished.

Decomposition:
- scarf_pkg holds:
  - FSM state enum (IDLE, HEADER, DATA);
  - SCARF_NO_SLAVE = 7'h00;
  - header bit positions (RNW_BIT = 7).
- One sub-module, scarf_sync_edge: a parameterized N-stage synchronizer with a per-instance reset value, producing sync/rise/fall outputs. Instantiated for sclk, cs_n and mosi; only the sync output is used for mosi.

Test Plan:
- Write: cs_n low; send 0x02, 0x00, 0x10, 0xA5; cs_n high → slave_id=7'h02 and rnw=0 after byte 0; three data_in_valid pulses with data 0x00, 0x10, 0xA5; one data_in_finished pulse; slave_id returns to 0.
- Read: header 0x82; stub returns 0x02, then 0x5A, then 0xC3 on successive loads; clock 4 bytes → miso bytes 0x00, 0x02, 0x5A, 0xC3; rnw=1 throughout; slave_id=7'h02.
- Partial byte: header 0x05, data 0x33, then 5 bits of 0xFF and cs_n rise → exactly one data_in_valid (0x33); data_in_finished pulses; data_in stays 0x33.
- Reset mid-transaction: assert rst_n_sync after 12 sclk bits with cs_n held low → all outputs 0; further sclk edges produce nothing until cs_n rises and falls; the next full transaction (0x02, 0x11) decodes correctly.
- Simultaneous end: cs_n rises 1 clk after the 8th rise of a data byte 0x7E → data_in_valid with 0x7E, followed by data_in_finished the next cycle.
- Noise: sclk toggles with cs_n high → no outputs change; miso stays 0.
